// File: rtl/digit_recog_pkg.sv
// Shared types and constants for the digit feature recogniser: FSM states,
// feature-line ratios and the feature-vector to digit lookup.
package digit_recog_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_LINES,
        S_DECODE,
        S_OUT
    } state_t;

    localparam int         K_V5       = 102;
    localparam int         K_V3       = 171;
    localparam int         K_SHIFT    = 8;
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    typedef struct packed {
        logic [1:0] cv;
        logic [1:0] c5;
        logic [1:0] c3;
        logic       l5;
        logic       r5;
        logic       l3;
        logic       r3;
    } feat_t;

    // Side flags listed for a digit must be set; unlisted flags are don't-care.
    // Rows are tried in digit order, so the first match wins.
    function automatic logic [3:0] decode_digit(input feat_t f);
        logic [3:0] d;
        d = DIGIT_NONE;
        if (f.cv == 2'd2 && f.c5 == 2'd2 && f.c3 == 2'd2)
            d = 4'd0;
        else if (f.cv == 2'd1 && f.c5 == 2'd1 && f.c3 == 2'd1)
            d = 4'd1;
        else if (f.cv == 2'd3 && f.c5 == 2'd1 && f.c3 == 2'd1 && f.r5 && f.l3)
            d = 4'd2;
        else if (f.cv == 2'd3 && f.c5 == 2'd1 && f.c3 == 2'd1 && f.r5 && f.r3)
            d = 4'd3;
        else if (f.cv == 2'd1 && f.c5 == 2'd2 && f.c3 == 2'd1 && f.r3)
            d = 4'd4;
        else if (f.cv == 2'd3 && f.c5 == 2'd1 && f.c3 == 2'd1 && f.l5 && f.r3)
            d = 4'd5;
        else if (f.cv == 2'd3 && f.c5 == 2'd1 && f.c3 == 2'd2 && f.l5)
            d = 4'd6;
        else if (f.cv == 2'd2 && f.c5 == 2'd1 && f.c3 == 2'd1 && f.r5 && f.r3)
            d = 4'd7;
        else if (f.cv == 2'd3 && f.c5 == 2'd2 && f.c3 == 2'd2)
            d = 4'd8;
        else if (f.cv == 2'd3 && f.c5 == 2'd2 && f.c3 == 2'd1 && f.r3)
            d = 4'd9;
        return d;
    endfunction

endpackage

// File: rtl/crossing_counter.sv
// Counts background-to-foreground transitions along one feature line,
// saturating at 3. The previous-pixel bit can be dropped at each line start.
module crossing_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       match,
    input  logic       fg,
    input  logic       clear,
    input  logic       prev_clear,
    output logic [1:0] count
);

    logic prev;
    logic prev_eff;

    // A line start forgets the last pixel in the same cycle it sees the first one.
    assign prev_eff = prev && !prev_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            prev  <= 1'b0;
        end else if (clear) begin
            count <= 2'd0;
            prev  <= 1'b0;
        end else if (enable) begin
            if (match) begin
                prev <= fg;
                if (fg && !prev_eff && count != 2'd3)
                    count <= count + 2'd1;
            end else if (prev_clear) begin
                prev <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/digit_feature_recog.sv
// Per-frame digit recogniser: bounding box of ROI foreground, three feature
// lines, stroke crossings on those lines and a table decode to 0-9.
module digit_feature_recog
    import digit_recog_pkg::*;
#(
    parameter int   ROI_X0   = 80,
    parameter int   ROI_X1   = 400,
    parameter int   ROI_Y0   = 80,
    parameter int   ROI_Y1   = 160,
    parameter logic FG_LEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic        i_bin,
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [3:0]  o_digit,
    output logic        o_valid,
    output logic        o_box_ok,
    output logic [11:0] h_2,
    output logic [11:0] v_5,
    output logic [11:0] v_3
);

    state_t      state;
    logic        vs_q, vs_q2, de_q;
    logic        vs_rise, de_rise, in_roi, fg, acc, acc_clear;
    logic        col_match, r5_match, r3_match;
    logic [11:0] xmin, xmax, ymin, ymax;
    logic        l5, r5, l3, r3;
    logic [1:0]  cnt_v, cnt_5, cnt_3;
    logic [11:0] nh_2, nv_5, nv_3;
    logic [11:0] hgt;
    logic [12:0] xsum;
    logic [19:0] p5, p3;
    logic        box_ok;
    feat_t       feat;

    assign vs_rise   = vs_q && !vs_q2;
    assign de_rise   = i_de && !de_q;
    assign in_roi    = (x >= 12'(ROI_X0)) && (x <= 12'(ROI_X1)) &&
                       (y >= 12'(ROI_Y0)) && (y <= 12'(ROI_Y1));
    assign fg        = i_de && (i_bin == FG_LEVEL) && in_roi;
    assign acc       = (state == S_ACC);
    assign acc_clear = ((state == S_IDLE) && vs_rise) || (state == S_OUT);
    assign col_match = i_de && (x == h_2);
    assign r5_match  = i_de && (y == v_5);
    assign r3_match  = i_de && (y == v_3);

    assign hgt    = ymax - ymin;
    assign xsum   = {1'b0, xmin} + {1'b0, xmax};
    assign p5     = {8'd0, hgt} * 20'(K_V5);
    assign p3     = {8'd0, hgt} * 20'(K_V3);
    assign box_ok = (xmax >= xmin);
    assign feat   = {cnt_v, cnt_5, cnt_3, l5, r5, l3, r3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            de_q  <= 1'b0;
        end else begin
            vs_q  <= i_vs;
            vs_q2 <= vs_q;
            de_q  <= i_de;
        end
    end

    // Lines on the outputs belong to the previous frame; counters compare against them.
    crossing_counter u_cv (
        .clk(clk), .rst_n(rst_n), .enable(acc), .match(col_match), .fg(fg),
        .clear(acc_clear), .prev_clear(1'b0), .count(cnt_v)
    );
    crossing_counter u_c5 (
        .clk(clk), .rst_n(rst_n), .enable(acc), .match(r5_match), .fg(fg),
        .clear(acc_clear), .prev_clear(de_rise), .count(cnt_5)
    );
    crossing_counter u_c3 (
        .clk(clk), .rst_n(rst_n), .enable(acc), .match(r3_match), .fg(fg),
        .clear(acc_clear), .prev_clear(de_rise), .count(cnt_3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin <= 12'hFFF;
            ymin <= 12'hFFF;
            xmax <= 12'd0;
            ymax <= 12'd0;
            {l5, r5, l3, r3} <= 4'b0;
        end else if (acc_clear) begin
            xmin <= 12'hFFF;
            ymin <= 12'hFFF;
            xmax <= 12'd0;
            ymax <= 12'd0;
            {l5, r5, l3, r3} <= 4'b0;
        end else if (acc && fg) begin
            if (x < xmin) xmin <= x;
            if (x > xmax) xmax <= x;
            if (y < ymin) ymin <= y;
            if (y > ymax) ymax <= y;
            if (y == v_5 && x < h_2) l5 <= 1'b1;
            if (y == v_5 && x > h_2) r5 <= 1'b1;
            if (y == v_3 && x < h_2) l3 <= 1'b1;
            if (y == v_3 && x > h_2) r3 <= 1'b1;
        end
    end

    // Outputs are loaded on the DECODE->OUT edge so they are visible while in S_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            o_digit  <= DIGIT_NONE;
            o_valid  <= 1'b0;
            o_box_ok <= 1'b0;
            h_2      <= 12'd0;
            v_5      <= 12'd0;
            v_3      <= 12'd0;
            nh_2     <= 12'd0;
            nv_5     <= 12'd0;
            nv_3     <= 12'd0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE:  if (vs_rise) state <= S_ACC;
                S_ACC:   if (vs_rise) state <= S_LINES;
                S_LINES: begin
                    nh_2  <= xsum[12:1];
                    nv_5  <= ymin + p5[K_SHIFT +: 12];
                    nv_3  <= ymin + p3[K_SHIFT +: 12];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    o_valid <= 1'b1;
                    state   <= S_OUT;
                    if (box_ok) begin
                        o_digit  <= decode_digit(feat);
                        o_box_ok <= 1'b1;
                        h_2      <= nh_2;
                        v_5      <= nv_5;
                        v_3      <= nv_3;
                    end else begin
                        o_digit  <= DIGIT_NONE;
                        o_box_ok <= 1'b0;
                    end
                end
                S_OUT:   state <= S_ACC;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_feature_recog.sv
// Bench for digit_feature_recog: frames built from rectangles, expected
// outputs from a frame-level reference model of the recognition rules.
module tb_digit_feature_recog;

    localparam int RX0 = 80, RX1 = 400, RY0 = 80, RY1 = 160;

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
    } rect_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vs, i_de, i_bin;
    logic [11:0] x, y;
    logic [3:0]  o_digit;
    logic        o_valid, o_box_ok;
    logic [11:0] h_2, v_5, v_3;

    int          errors = 0;
    int          checks = 0;
    rect_t       rects[$];
    logic [3:0]  exp_q[$];
    int          m_h2 = 0, m_v5 = 0, m_v3 = 0;
    bit          pend_box = 0;

    int       t_cv [10] = '{2, 1, 3, 3, 1, 3, 3, 2, 3, 3};
    int       t_c5 [10] = '{2, 1, 1, 1, 2, 1, 1, 1, 2, 2};
    int       t_c3 [10] = '{2, 1, 1, 1, 1, 1, 2, 1, 2, 1};
    bit [3:0] t_req[10] = '{4'b0000, 4'b0000, 4'b0110, 4'b0101, 4'b0001,
                            4'b1001, 4'b1000, 4'b0101, 4'b0000, 4'b0001};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    digit_feature_recog dut (
        .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_de(i_de), .i_bin(i_bin),
        .x(x), .y(y), .o_digit(o_digit), .o_valid(o_valid), .o_box_ok(o_box_ok),
        .h_2(h_2), .v_5(v_5), .v_3(v_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit pix(input int px, input int py);
        foreach (rects[i])
            if (px >= rects[i].x0 && px <= rects[i].x1 && py >= rects[i].y0 && py <= rects[i].y1)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit fg_m(input int px, input int py);
        return pix(px, py) && px >= RX0 && px <= RX1 && py >= RY0 && py <= RY1;
    endfunction

    function automatic int row_runs(input int row, input int wx0, input int wx1,
                                    input int wy0, input int wy1);
        int n = 0;
        bit prev = 1'b0;
        bit f;
        if (row < wy0 || row > wy1) return 0;
        for (int xx = wx0; xx <= wx1; xx++) begin
            f = fg_m(xx, row);
            if (f && !prev) n++;
            prev = f;
        end
        return (n > 3) ? 3 : n;
    endfunction

    function automatic int decode_model(input int cv, input int c5, input int c3, input bit [3:0] flags);
        for (int d = 0; d < 10; d++)
            if (cv == t_cv[d] && c5 == t_c5[d] && c3 == t_c3[d] && (flags & t_req[d]) == t_req[d])
                return d;
        return 15;
    endfunction

    task automatic model_frame(input int wx0, input int wx1, input int wy0, input int wy1);
        int xmin = 4095, xmax = 0, ymin = 4095, ymax = 0;
        int cv = 0, c5, c3, hgt;
        bit l5 = 0, r5 = 0, l3 = 0, r3 = 0, prev = 0, f;
        for (int yy = wy0; yy <= wy1; yy++)
            for (int xx = wx0; xx <= wx1; xx++)
                if (fg_m(xx, yy)) begin
                    if (xx < xmin) xmin = xx;
                    if (xx > xmax) xmax = xx;
                    if (yy < ymin) ymin = yy;
                    if (yy > ymax) ymax = yy;
                    if (yy == m_v5 && xx < m_h2) l5 = 1;
                    if (yy == m_v5 && xx > m_h2) r5 = 1;
                    if (yy == m_v3 && xx < m_h2) l3 = 1;
                    if (yy == m_v3 && xx > m_h2) r3 = 1;
                end
        if (m_h2 >= wx0 && m_h2 <= wx1)
            for (int yy = wy0; yy <= wy1; yy++) begin
                f = fg_m(m_h2, yy);
                if (f && !prev) cv++;
                prev = f;
            end
        if (cv > 3) cv = 3;
        c5 = row_runs(m_v5, wx0, wx1, wy0, wy1);
        c3 = row_runs(m_v3, wx0, wx1, wy0, wy1);
        if (xmax >= xmin) begin
            exp_q.push_back(4'(decode_model(cv, c5, c3, {l5, r5, l3, r3})));
            hgt  = ymax - ymin;
            m_h2 = (xmin + xmax) / 2;
            m_v5 = ymin + (hgt * 102) / 256;
            m_v3 = ymin + (hgt * 171) / 256;
            pend_box = 1'b1;
        end else begin
            exp_q.push_back(4'hF);
            pend_box = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_frame(input int wx0, input int wx1, input int wy0, input int wy1);
        for (int yy = wy0; yy <= wy1; yy++) begin
            for (int xx = wx0; xx <= wx1; xx++) begin
                x     = 12'(xx);
                y     = 12'(yy);
                i_de  = 1'b1;
                i_bin = pix(xx, yy);
                tick();
            end
            i_de  = 1'b0;
            i_bin = 1'($urandom_range(0, 1));
            tick();
            tick();
        end
    endtask

    // Pulses vsync and checks the o_valid timing plus, when a result is due, the outputs.
    task automatic vsync(input string tag, input bit expect_out);
        int first_k = 0;
        int n_valid = 0;
        logic [3:0] exp_d;
        i_vs = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) i_vs = 1'b0;
            if (o_valid === 1'b1) begin
                n_valid++;
                if (first_k == 0) first_k = k;
            end
            if (k == 4 && expect_out) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_queue"}, 0, 1);
                end else begin
                    exp_d = exp_q.pop_front();
                    check({tag, "_digit"}, o_digit, exp_d);
                    check({tag, "_box_ok"}, o_box_ok, pend_box);
                    check({tag, "_h_2"}, h_2, m_h2);
                    check({tag, "_v_5"}, v_5, m_v5);
                    check({tag, "_v_3"}, v_3, m_v3);
                end
            end
        end
        check({tag, "_valid_latency"}, first_k, expect_out ? 4 : 0);
        check({tag, "_valid_width"}, n_valid, expect_out ? 1 : 0);
    endtask

    task automatic run_frame(input string tag, input int wx0, input int wx1,
                             input int wy0, input int wy1);
        drive_frame(wx0, wx1, wy0, wy1);
        model_frame(wx0, wx1, wy0, wy1);
        vsync(tag, 1'b1);
    endtask

    task automatic set_bar();
        rects.delete();
        rects.push_back('{200, 209, 90, 150});
    endtask

    task automatic set_ring();
        rects.delete();
        rects.push_back('{150, 250, 90, 93});
        rects.push_back('{150, 250, 147, 150});
        rects.push_back('{150, 153, 90, 150});
        rects.push_back('{247, 250, 90, 150});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, o_digit, 4'hF);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_box_ok"}, o_box_ok, 1'b0);
        check({tag, "_h_2"}, h_2, 0);
        check({tag, "_v_5"}, v_5, 0);
        check({tag, "_v_3"}, v_3, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int nr, x0, y0;
        rst_n = 1'b0;
        i_vs  = 1'b0;
        i_de  = 1'b0;
        i_bin = 1'b0;
        x     = '0;
        y     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // First edge only opens accumulation; then two empty frames.
        vsync("idle_enter", 1'b0);
        rects.delete();
        run_frame("empty1", 100, 109, 100, 104);
        run_frame("empty2", 100, 109, 100, 104);

        set_bar();
        run_frame("bar1", 195, 215, 85, 155);
        check("bar1_h_2_const", h_2, 204);
        check("bar1_v_5_const", v_5, 113);
        check("bar1_v_3_const", v_3, 130);
        check("bar1_digit_const", o_digit, 4'hF);
        run_frame("bar2", 195, 215, 85, 155);
        check("bar2_digit_const", o_digit, 4'd1);

        set_ring();
        run_frame("ring1", 145, 255, 86, 154);
        run_frame("ring2", 145, 255, 86, 154);
        check("ring2_digit_const", o_digit, 4'd0);

        rects.delete();
        rects.push_back('{45, 55, 90, 150});
        run_frame("outside", 40, 60, 88, 152);
        check("outside_box_const", o_box_ok, 1'b0);

        // Shapes straddling the inclusive ROI corners.
        rects.delete();
        rects.push_back('{76, 84, 76, 84});
        run_frame("roi_tl", 74, 86, 74, 86);
        rects.delete();
        rects.push_back('{396, 404, 156, 164});
        run_frame("roi_br", 394, 406, 154, 166);

        // Random strokes, each shape shown twice so the second pass uses its own lines.
        for (int s = 0; s < 3; s++) begin
            rects.delete();
            nr = $urandom_range(1, 3);
            for (int r = 0; r < nr; r++) begin
                x0 = $urandom_range(160, 235);
                y0 = $urandom_range(88, 145);
                rects.push_back('{x0, (x0 + int'($urandom_range(0, 40)) > 240) ? 240 : x0 + int'($urandom_range(0, 40)),
                                  y0, (y0 + int'($urandom_range(0, 40)) > 150) ? 150 : y0 + int'($urandom_range(0, 40))});
            end
            run_frame($sformatf("rand%0da", s), 160, 240, 88, 150);
            run_frame($sformatf("rand%0db", s), 160, 240, 88, 150);
        end

        // Asynchronous reset in the middle of an accumulating frame.
        set_bar();
        drive_frame(195, 215, 85, 100);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        m_h2 = 0;
        m_v5 = 0;
        m_v3 = 0;
        exp_q.delete();
        tick();
        vsync("post_reset_enter", 1'b0);
        run_frame("post_reset1", 195, 215, 85, 155);
        run_frame("post_reset2", 195, 215, 85, 155);
        check("post_reset2_digit_const", o_digit, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
